// File: rtl/dpsram_fifo_ctrl_pkg.sv
// rtl/dpsram_fifo_ctrl_pkg.sv - shared types for the dual-port RAM FIFO controller
package dpsram_fifo_ctrl_pkg;
  `include "dpsram_ctrl_defs.vh"

  // Read sequencer states; S_EMPTY/S_FILL differ only by a read in flight.
  typedef enum logic [1:0] {
    S_EMPTY = ST_EMPTY,
    S_FILL  = ST_FILL,
    S_ONE   = ST_ONE,
    S_TWO   = ST_TWO
  } state_t;

  // Number of words held in the output stage for a given sequencer state.
  function automatic logic [1:0] stage_occupancy(input state_t st);
    case (st)
      S_ONE:   return 2'd1;
      S_TWO:   return 2'd2;
      default: return 2'd0;
    endcase
  endfunction
endpackage

// File: rtl/dpsram_ctrl_defs.vh
// rtl/dpsram_ctrl_defs.vh - read sequencer state encodings shared by RTL and bench
localparam logic [1:0] ST_EMPTY = 2'd0;
localparam logic [1:0] ST_FILL  = 2'd1;
localparam logic [1:0] ST_ONE   = 2'd2;
localparam logic [1:0] ST_TWO   = 2'd3;

// File: rtl/dpsram_model.sv
// rtl/dpsram_model.sv - simple dual-port RAM, registered read, write-first on address collision
module dpsram_model #(
  parameter logic [15:0] P_LENGTH   = 16'd1024,
  parameter logic [15:0] P_ADDR_LEN = 16'd10,
  parameter logic [15:0] P_BITDEPTH = 16'd16
) (
  input  logic                  i_wrclk,
  input  logic                  i_wr_en,
  input  logic [P_ADDR_LEN-1:0] i_wr_addr,
  input  logic [P_BITDEPTH-1:0] i_wr_data,
  input  logic                  i_rdclk,
  input  logic                  i_rd_en,
  input  logic [P_ADDR_LEN-1:0] i_rd_addr,
  output logic [P_BITDEPTH-1:0] o_rd_data
);

  logic [P_BITDEPTH-1:0] mem [0:P_LENGTH-1];

  // Write port: store the word at the write address.
  always_ff @(posedge i_wrclk) begin
    if (i_wr_en) begin
      mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read port: one-cycle latency; a same-cycle write to the read address is forwarded
  // so a word pushed into an empty FIFO can be read in the cycle it is written.
  always_ff @(posedge i_rdclk) begin
    if (i_rd_en) begin
      if (i_wr_en && (i_wr_addr == i_rd_addr)) begin
        o_rd_data <= i_wr_data;
      end else begin
        o_rd_data <= mem[i_rd_addr];
      end
    end
  end

endmodule

// File: rtl/dpsram_fifo_ctrl.sv
// rtl/dpsram_fifo_ctrl.sv - FIFO controller over a dual-port RAM with a 2-entry fall-through output stage
module dpsram_fifo_ctrl
  import dpsram_fifo_ctrl_pkg::*;
#(
  parameter logic [15:0] P_LENGTH   = 16'd1024,
  parameter logic [15:0] P_ADDR_LEN = 16'd10,
  parameter logic [15:0] P_BITDEPTH = 16'd16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic                  i_s_valid,
  output logic                  o_s_ready,
  input  logic [P_BITDEPTH-1:0] i_s_data,
  output logic                  o_m_valid,
  input  logic                  i_m_ready,
  output logic [P_BITDEPTH-1:0] o_m_data,
  output logic [P_ADDR_LEN:0]   o_count,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int CW = int'(P_ADDR_LEN) + 1;
  localparam logic [P_ADDR_LEN:0]   LEN_C    = CW'(P_LENGTH);
  localparam logic [P_ADDR_LEN-1:0] LAST_PTR = P_ADDR_LEN'(P_LENGTH - 16'd1);
  localparam logic [P_ADDR_LEN-1:0] PTR_ONE  = P_ADDR_LEN'(1);

  logic                  push;
  logic                  pop;
  logic                  issue;
  logic                  slot_free;
  logic                  rd_pend;
  logic [1:0]            stg_cnt;
  logic [1:0]            stg_next;
  logic [P_ADDR_LEN-1:0] wr_ptr;
  logic [P_ADDR_LEN-1:0] rd_ptr;
  logic [P_ADDR_LEN:0]   ram_cnt;
  logic [P_ADDR_LEN:0]   count_next;
  logic [P_BITDEPTH-1:0] ram_rdata;
  logic [P_BITDEPTH-1:0] stage_head;
  logic [P_BITDEPTH-1:0] stage_tail;
  state_t                state;

  assign o_s_ready = !o_full && !i_rst && !i_flush;
  assign push      = i_s_valid && o_s_ready;
  assign pop       = o_m_valid && i_m_ready;
  assign o_m_data  = stage_head;

  // Stage occupancy plus the read in flight must leave room for one more returned word.
  assign stg_cnt    = stage_occupancy(state);
  assign slot_free  = (stg_cnt + {1'b0, rd_pend}) < 2'd2;
  assign stg_next   = stg_cnt + {1'b0, rd_pend} - {1'b0, pop};
  assign count_next = o_count + CW'(push) - CW'(pop);

  // A word being pushed this cycle already counts as unread: the RAM forwards it.
  assign issue = !i_rst && !i_flush && ((ram_cnt != '0) || push) && (slot_free || pop);

  dpsram_model #(
    .P_LENGTH  (P_LENGTH),
    .P_ADDR_LEN(P_ADDR_LEN),
    .P_BITDEPTH(P_BITDEPTH)
  ) u_ram (
    .i_wrclk  (i_clk),
    .i_wr_en  (push),
    .i_wr_addr(wr_ptr),
    .i_wr_data(i_s_data),
    .i_rdclk  (i_clk),
    .i_rd_en  (issue),
    .i_rd_addr(rd_ptr),
    .o_rd_data(ram_rdata)
  );

  // Pointers, unread-word count and the user-visible occupancy flags.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_cnt <= '0;
      o_count <= '0;
      o_full  <= 1'b0;
      o_empty <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_ONE;
      end
      if (issue) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_ONE;
      end
      ram_cnt <= ram_cnt + CW'(push) - CW'(issue);
      o_count <= count_next;
      o_full  <= (count_next == LEN_C);
      o_empty <= (count_next == '0);
    end
  end

  // Read sequencer: tracks stage occupancy and the outstanding RAM read.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      state     <= S_EMPTY;
      rd_pend   <= 1'b0;
      o_m_valid <= 1'b0;
    end else begin
      rd_pend   <= issue;
      o_m_valid <= (stg_next != 2'd0);
      case (stg_next)
        2'd0:    state <= issue ? S_FILL : S_EMPTY;
        2'd1:    state <= S_ONE;
        default: state <= S_TWO;
      endcase
    end
  end

  // Output stage data: pop shifts tail to head, returned RAM data fills the next free slot.
  always_ff @(posedge i_clk) begin
    case ({pop, rd_pend})
      2'b10: begin
        stage_head <= stage_tail;
      end
      2'b01: begin
        if (stg_cnt == 2'd0) begin
          stage_head <= ram_rdata;
        end else begin
          stage_tail <= ram_rdata;
        end
      end
      2'b11: begin
        if (stg_cnt == 2'd1) begin
          stage_head <= ram_rdata;
        end else begin
          stage_head <= stage_tail;
          stage_tail <= ram_rdata;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_dpsram_fifo_ctrl.sv
// tb/tb_dpsram_fifo_ctrl.sv - scoreboard bench for dpsram_fifo_ctrl at depth 5
module tb_dpsram_fifo_ctrl;
  `include "dpsram_ctrl_defs.vh"

  localparam int DEPTH = 5;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic [3:0]  count;
  logic        full;
  logic        empty;

  int          n_checks = 0;
  int          n_fail = 0;
  int          model_cnt = 0;
  logic [15:0] exp_q[$];

  dpsram_fifo_ctrl #(
    .P_LENGTH  (16'd5),
    .P_ADDR_LEN(16'd3),
    .P_BITDEPTH(16'd16)
  ) u_dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_flush  (flush),
    .i_s_valid(s_valid),
    .o_s_ready(s_ready),
    .i_s_data (s_data),
    .o_m_valid(m_valid),
    .i_m_ready(m_ready),
    .o_m_data (m_data),
    .o_count  (count),
    .o_full   (full),
    .o_empty  (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: scoreboard compare of popped data at negedge, model update at posedge.
  task automatic tick();
    logic        pop_m;
    logic        push_m;
    logic [15:0] exp_w;
    @(negedge clk);
    pop_m  = m_valid && m_ready;
    push_m = s_valid && (model_cnt < DEPTH) && !rst && !flush;
    if (pop_m && !rst && !flush) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_pop: got data %h with nothing expected", m_data);
      end else begin
        exp_w = exp_q.pop_front();
        if (m_data !== exp_w) begin
          n_fail++;
          $display("FAIL sb_data: got %h expected %h", m_data, exp_w);
        end
      end
    end
    @(posedge clk);
    if (rst || flush) begin
      exp_q.delete();
      model_cnt = 0;
    end else begin
      if (push_m) exp_q.push_back(s_data);
      model_cnt = model_cnt + (push_m ? 1 : 0) - (pop_m ? 1 : 0);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", s_ready); end
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", m_valid); end
    n_checks++; if (empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got empty=%b full=%b expected 1/0", empty, full); end
    n_checks++; if (u_dut.state !== ST_EMPTY) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", u_dut.state, ST_EMPTY); end
    n_checks++; if (u_dut.wr_ptr !== 3'd0 || u_dut.rd_ptr !== 3'd0) begin n_fail++; $display("FAIL reset_ptrs: got wr=%0d rd=%0d expected 0/0", u_dut.wr_ptr, u_dut.rd_ptr); end
    rst = 1'b0;
    #1;
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b expected 1", s_ready); end
  endtask

  task automatic test_first_word();
    s_valid = 1'b1; s_data = 16'h1234;
    tick();
    s_valid = 1'b0;
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL fwft_n1_valid: got %b expected 0", m_valid); end
    n_checks++; if (u_dut.state !== ST_FILL) begin n_fail++; $display("FAIL fwft_n1_state: got %0d expected %0d", u_dut.state, ST_FILL); end
    tick();
    n_checks++; if (m_valid !== 1'b1 || m_data !== 16'h1234) begin n_fail++; $display("FAIL fwft_n2: got valid=%b data=%h expected 1/1234", m_valid, m_data); end
    n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL fwft_count: got %0d expected 1", count); end
    n_checks++; if (u_dut.state !== ST_ONE) begin n_fail++; $display("FAIL fwft_state: got %0d expected %0d", u_dut.state, ST_ONE); end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    n_checks++; if (empty !== 1'b1 || count !== 4'd0) begin n_fail++; $display("FAIL fwft_drain: got empty=%b count=%0d expected 1/0", empty, count); end
  endtask

  task automatic test_fill_to_full();
    for (int i = 1; i <= DEPTH; i++) begin
      s_valid = 1'b1; s_data = 16'(i);
      tick();
    end
    s_valid = 1'b0;
    n_checks++; if (full !== 1'b1 || s_ready !== 1'b0) begin n_fail++; $display("FAIL full_flags: got full=%b ready=%b expected 1/0", full, s_ready); end
    n_checks++; if (count !== 4'd5) begin n_fail++; $display("FAIL full_count: got %0d expected 5", count); end
    s_valid = 1'b1; s_data = 16'h0006;
    tick();
    s_valid = 1'b0;
    n_checks++; if (count !== 4'd5) begin n_fail++; $display("FAIL full_ignore_push: got %0d expected 5", count); end
    tick();
    tick();
    n_checks++; if (u_dut.state !== ST_TWO) begin n_fail++; $display("FAIL full_state: got %0d expected %0d", u_dut.state, ST_TWO); end
    m_ready = 1'b1;
    for (int c = 0; c < 20 && model_cnt > 0; c++) tick();
    m_ready = 1'b0;
    n_checks++; if (model_cnt != 0) begin n_fail++; $display("FAIL full_drain_timeout: got %0d words left expected 0", model_cnt); end
    n_checks++; if (empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL full_drain_flags: got empty=%b full=%b expected 1/0", empty, full); end
  endtask

  task automatic test_back_to_back();
    int         pushed = 0;
    int         pops = 0;
    int         first_pop = -1;
    int         last_pop = -1;
    int         wr_wraps = 0;
    int         rd_wraps = 0;
    logic [2:0] pw;
    logic [2:0] pr;
    m_ready = 1'b1;
    for (int c = 0; c < 80 && (pushed < 20 || model_cnt > 0); c++) begin
      s_valid = (pushed < 20);
      s_data  = 16'hA000 + 16'(pushed);
      if (m_valid) begin
        pops++;
        if (first_pop < 0) first_pop = c;
        last_pop = c;
      end
      pw = u_dut.wr_ptr;
      pr = u_dut.rd_ptr;
      tick();
      if (s_valid) pushed++;
      if (pw == 3'd4 && u_dut.wr_ptr == 3'd0) wr_wraps++;
      if (pr == 3'd4 && u_dut.rd_ptr == 3'd0) rd_wraps++;
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    n_checks++; if (pops != 20) begin n_fail++; $display("FAIL stream_pops: got %0d expected 20", pops); end
    n_checks++; if (last_pop - first_pop != 19) begin n_fail++; $display("FAIL stream_bubbles: got span %0d expected 19", last_pop - first_pop); end
    n_checks++; if (wr_wraps != 4 || rd_wraps != 4) begin n_fail++; $display("FAIL stream_wraps: got wr=%0d rd=%0d expected 4/4", wr_wraps, rd_wraps); end
    n_checks++; if (empty !== 1'b1 || model_cnt != 0) begin n_fail++; $display("FAIL stream_end: got empty=%b left=%0d expected 1/0", empty, model_cnt); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < DEPTH; i++) begin
      s_valid = 1'b1; s_data = 16'hC000 + 16'(i);
      tick();
    end
    s_valid = 1'b0;
    tick();
    tick();
    tick();
    n_checks++; if (count !== 4'd5) begin n_fail++; $display("FAIL fpp_prefill: got %0d expected 5", count); end
    s_valid = 1'b1; s_data = 16'h00A1; m_ready = 1'b1;
    tick();
    n_checks++; if (count !== 4'd4) begin n_fail++; $display("FAIL fpp_count_after: got %0d expected 4", count); end
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL fpp_ready_after: got %b expected 1", s_ready); end
    s_data = 16'h00A2; m_ready = 1'b0;
    tick();
    s_valid = 1'b0;
    n_checks++; if (count !== 4'd5) begin n_fail++; $display("FAIL fpp_refill: got %0d expected 5", count); end
    m_ready = 1'b1;
    for (int c = 0; c < 20 && model_cnt > 0; c++) tick();
    m_ready = 1'b0;
    n_checks++; if (model_cnt != 0 || empty !== 1'b1) begin n_fail++; $display("FAIL fpp_drain: got left=%0d empty=%b expected 0/1", model_cnt, empty); end
  endtask

  task automatic test_hold_flush();
    logic [15:0] hold;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = 16'h5100 + 16'(i);
      tick();
    end
    s_valid = 1'b0;
    for (int c = 0; c < 10 && !m_valid; c++) tick();
    n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid_timeout: got %b expected 1", m_valid); end
    hold = exp_q[0];
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++; if (m_valid !== 1'b1 || m_data !== hold) begin n_fail++; $display("FAIL hold_stable: got valid=%b data=%h expected 1/%h", m_valid, m_data, hold); end
    end
    flush = 1'b1; m_ready = 1'b1;
    tick();
    flush = 1'b0; m_ready = 1'b0;
    n_checks++; if (count !== 4'd0 || m_valid !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL flush_clear: got count=%0d valid=%b empty=%b expected 0/0/1", count, m_valid, empty); end
    n_checks++; if (u_dut.state !== ST_EMPTY || u_dut.wr_ptr !== 3'd0) begin n_fail++; $display("FAIL flush_state: got state=%0d wr=%0d expected %0d/0", u_dut.state, u_dut.wr_ptr, ST_EMPTY); end
    s_valid = 1'b1; s_data = 16'h5A5A;
    tick();
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int c = 0; c < 10 && model_cnt > 0; c++) tick();
    m_ready = 1'b0;
    n_checks++; if (model_cnt != 0 || empty !== 1'b1) begin n_fail++; $display("FAIL flush_reuse: got left=%0d empty=%b expected 0/1", model_cnt, empty); end
  endtask

  task automatic test_reset_midop();
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = 16'h7700 + 16'(i);
      tick();
    end
    s_valid = 1'b0; m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    n_checks++; if (count !== 4'd3 || u_dut.rd_pend !== 1'b1) begin n_fail++; $display("FAIL midop_setup: got count=%0d pend=%b expected 3/1", count, u_dut.rd_pend); end
    rst = 1'b1;
    tick();
    n_checks++; if (count !== 4'd0 || m_valid !== 1'b0 || empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL midop_reset: got count=%0d valid=%b empty=%b full=%b expected 0/0/1/0", count, m_valid, empty, full); end
    n_checks++; if (u_dut.state !== ST_EMPTY || u_dut.wr_ptr !== 3'd0 || u_dut.rd_ptr !== 3'd0) begin n_fail++; $display("FAIL midop_state: got state=%0d wr=%0d rd=%0d expected %0d/0/0", u_dut.state, u_dut.wr_ptr, u_dut.rd_ptr, ST_EMPTY); end
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL midop_ready_in_reset: got %b expected 0", s_ready); end
    rst = 1'b0;
    #1;
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL midop_ready_release: got %b expected 1", s_ready); end
    s_valid = 1'b1; s_data = 16'hBEEF;
    tick();
    s_valid = 1'b0;
    tick();
    n_checks++; if (m_valid !== 1'b1 || m_data !== 16'hBEEF) begin n_fail++; $display("FAIL midop_beef: got valid=%b data=%h expected 1/beef", m_valid, m_data); end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    n_checks++; if (empty !== 1'b1 || model_cnt != 0) begin n_fail++; $display("FAIL midop_drain: got empty=%b left=%0d expected 1/0", empty, model_cnt); end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; s_valid = 1'b0; s_data = 16'h0000; m_ready = 1'b0;
    test_reset();
    test_first_word();
    test_fill_to_full();
    test_back_to_back();
    test_full_push_pop();
    test_hold_flush();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
